// File: rtl/tlul_xbar_nto1.sv
// N-host to single-device TL-UL crossbar with an in-order response-routing FIFO.
// Define TLUL_XBAR_RR_ARB_EN for round-robin arbitration; the default build uses fixed priority.

package tlul_pkg;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

endpackage

module tlul_xbar_nto1 #(
    parameter int NumHosts       = 3,
    parameter int MaxOutstanding = 4
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  tlul_pkg::tl_h2d_t                    tl_h_i [NumHosts],
    output tlul_pkg::tl_d2h_t                    tl_h_o [NumHosts],
    output tlul_pkg::tl_h2d_t                    tl_d_o,
    input  tlul_pkg::tl_d2h_t                    tl_d_i,
    output logic [$clog2(MaxOutstanding+1)-1:0]  outstanding_o,
    output logic                                 spurious_rsp_o
);

    localparam int IdxW = $clog2(NumHosts);
    localparam int PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int CntW = $clog2(MaxOutstanding + 1);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    logic [0:0]      state;
    logic [IdxW-1:0] owner;

    logic [IdxW-1:0] fifo_mem [MaxOutstanding];
    logic [PtrW-1:0] wr_ptr;
    logic [PtrW-1:0] rd_ptr;
    logic [CntW-1:0] count;
    logic            fifo_full;
    logic            fifo_empty;
    logic [IdxW-1:0] head;

    logic            pick_valid;
    logic [IdxW-1:0] pick_idx;
    logic            sel_valid;
    logic [IdxW-1:0] sel_idx;
    logic            a_hs;
    logic            d_hs;
    logic            spurious_q;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + 1'b1;
    endfunction

    assign fifo_full  = (count == CntW'(MaxOutstanding));
    assign fifo_empty = (count == '0);
    assign head       = fifo_mem[rd_ptr];

`ifdef TLUL_XBAR_RR_ARB_EN
    logic [IdxW-1:0] rr_ptr;

    // Walk offsets from far to near so the host closest to the pointer wins.
    always_comb begin
        int              cand;
        logic [IdxW-1:0] cand_idx;
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        cand_idx   = '0;
        for (int off = NumHosts - 1; off >= 0; off--) begin
            cand     = (int'(rr_ptr) + off) % NumHosts;
            cand_idx = IdxW'(cand);
            if (tl_h_i[cand_idx].a_valid) begin
                pick_valid = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr <= '0;
        end else if (a_hs) begin
            rr_ptr <= (sel_idx == IdxW'(NumHosts - 1)) ? '0 : sel_idx + 1'b1;
        end
    end
`else
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int i = NumHosts - 1; i >= 0; i--) begin
            if (tl_h_i[i].a_valid) begin
                pick_valid = 1'b1;
                pick_idx   = IdxW'(i);
            end
        end
    end
`endif

    // A locked owner keeps the channel; a new pick needs FIFO room and no reset.
    always_comb begin
        if (state == ST_LOCKED) begin
            sel_valid = 1'b1;
            sel_idx   = owner;
        end else begin
            sel_valid = pick_valid && !fifo_full && !rst_i;
            sel_idx   = pick_idx;
        end
    end

    assign a_hs = sel_valid && tl_h_i[sel_idx].a_valid && tl_d_i.a_ready;
    assign d_hs = !fifo_empty && tl_d_i.d_valid && tl_h_i[head].d_ready;

    always_comb begin
        tl_d_o = '0;
        if (sel_valid) begin
            tl_d_o = tl_h_i[sel_idx];
        end
        tl_d_o.d_ready = fifo_empty ? 1'b1 : tl_h_i[head].d_ready;
    end

    always_comb begin
        for (int i = 0; i < NumHosts; i++) begin
            tl_h_o[i]         = tl_d_i;
            tl_h_o[i].a_ready = sel_valid && (sel_idx == IdxW'(i)) && tl_d_i.a_ready;
            tl_h_o[i].d_valid = !fifo_empty && (head == IdxW'(i)) && tl_d_i.d_valid;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
            owner <= '0;
        end else if (a_hs) begin
            state <= ST_IDLE;
        end else if (sel_valid && tl_h_i[sel_idx].a_valid) begin
            state <= ST_LOCKED;
            owner <= sel_idx;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (a_hs) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (d_hs) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (a_hs && !d_hs) begin
                count <= count + 1'b1;
            end else if (!a_hs && d_hs) begin
                count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (a_hs) begin
            fifo_mem[wr_ptr] <= sel_idx;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            spurious_q <= 1'b0;
        end else if (fifo_empty && tl_d_i.d_valid) begin
            spurious_q <= 1'b1;
        end
    end

    assign outstanding_o  = count;
    assign spurious_rsp_o = spurious_q;

endmodule

// File: tb/tb_tlul_xbar_nto1.sv
// Directed bench for tlul_xbar_nto1 (3 hosts, 2 outstanding): vector table plus
// hand-written arbitration, full-FIFO and asynchronous-reset sequences.

module tb_tlul_xbar_nto1;
    import tlul_pkg::*;

    localparam int NumHosts = 3;
    localparam int MaxOut   = 2;

    typedef struct {
        logic [2:0] av;
        logic       dar;
        logic       ddv;
        logic [2:0] dr;
        logic [2:0] exp_ar;
        logic [2:0] exp_dv;
        logic       exp_dav;
        logic [7:0] exp_src;
        logic       exp_drdy;
        logic [1:0] exp_out;
        logic       exp_spur;
    } vec_t;

    logic       clk;
    logic       rst;
    tl_h2d_t    h_req [NumHosts];
    tl_d2h_t    h_rsp [NumHosts];
    tl_h2d_t    d_req;
    tl_d2h_t    d_rsp;
    logic [1:0] outstanding;
    logic       spurious;
    logic [2:0] a_ready_bits;
    logic [2:0] d_valid_bits;

    int errors = 0;
    int checks = 0;

    vec_t vecs [25];

    tlul_xbar_nto1 #(
        .NumHosts       (NumHosts),
        .MaxOutstanding (MaxOut)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .tl_h_i         (h_req),
        .tl_h_o         (h_rsp),
        .tl_d_o         (d_req),
        .tl_d_i         (d_rsp),
        .outstanding_o  (outstanding),
        .spurious_rsp_o (spurious)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NumHosts; i++) begin
            a_ready_bits[i] = h_rsp[i].a_ready;
            d_valid_bits[i] = h_rsp[i].d_valid;
        end
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input logic [2:0] av, input logic dar, input logic ddv,
                                  input logic [2:0] dr);
        for (int i = 0; i < NumHosts; i++) begin
            h_req[i].a_valid = av[i];
            h_req[i].d_ready = dr[i];
        end
        d_rsp.a_ready = dar;
        d_rsp.d_valid = ddv;
    endtask

    task automatic reset_dut();
        apply_stimulus(3'b000, 1'b1, 1'b0, 3'b111);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic step(input logic [2:0] av, input logic dar, input logic ddv, input logic [2:0] dr);
        @(negedge clk);
        apply_stimulus(av, dar, ddv, dr);
        #2;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        for (int i = 0; i < NumHosts; i++) begin
            h_req[i]           = '0;
            h_req[i].a_opcode  = 3'd4;
            h_req[i].a_source  = 8'h10 + 8'(i);
            h_req[i].a_address = 32'h1000 * (i + 1);
            h_req[i].a_mask    = 4'hF;
            h_req[i].a_data    = 32'hDA7A_0000 + 32'(i);
        end
        d_rsp = '0;

        // av, dar, ddv, dr | a_ready, d_valid, dev a_valid, a_source, dev d_ready, outstanding, spurious
        vecs[0]  = '{3'b000, 1'b1, 1'b0, 3'b111, 3'b000, 3'b000, 1'b0, 8'h00, 1'b1, 2'd0, 1'b0};
        vecs[1]  = '{3'b010, 1'b0, 1'b0, 3'b111, 3'b000, 3'b000, 1'b1, 8'h11, 1'b1, 2'd0, 1'b0};
        vecs[2]  = '{3'b011, 1'b0, 1'b0, 3'b111, 3'b000, 3'b000, 1'b1, 8'h11, 1'b1, 2'd0, 1'b0};
        vecs[3]  = '{3'b011, 1'b0, 1'b0, 3'b111, 3'b000, 3'b000, 1'b1, 8'h11, 1'b1, 2'd0, 1'b0};
        vecs[4]  = '{3'b011, 1'b1, 1'b0, 3'b111, 3'b010, 3'b000, 1'b1, 8'h11, 1'b1, 2'd0, 1'b0};
        vecs[5]  = '{3'b001, 1'b1, 1'b0, 3'b111, 3'b001, 3'b000, 1'b1, 8'h10, 1'b1, 2'd1, 1'b0};
        vecs[6]  = '{3'b000, 1'b1, 1'b1, 3'b111, 3'b000, 3'b010, 1'b0, 8'h00, 1'b1, 2'd2, 1'b0};
        vecs[7]  = '{3'b000, 1'b1, 1'b1, 3'b110, 3'b000, 3'b001, 1'b0, 8'h00, 1'b0, 2'd1, 1'b0};
        vecs[8]  = '{3'b000, 1'b1, 1'b1, 3'b111, 3'b000, 3'b001, 1'b0, 8'h00, 1'b1, 2'd1, 1'b0};
        vecs[9]  = '{3'b000, 1'b1, 1'b0, 3'b111, 3'b000, 3'b000, 1'b0, 8'h00, 1'b1, 2'd0, 1'b0};
        vecs[10] = '{3'b100, 1'b1, 1'b0, 3'b111, 3'b100, 3'b000, 1'b1, 8'h12, 1'b1, 2'd0, 1'b0};
        vecs[11] = '{3'b001, 1'b1, 1'b0, 3'b111, 3'b001, 3'b000, 1'b1, 8'h10, 1'b1, 2'd1, 1'b0};
        vecs[12] = '{3'b000, 1'b1, 1'b1, 3'b111, 3'b000, 3'b100, 1'b0, 8'h00, 1'b1, 2'd2, 1'b0};
        vecs[13] = '{3'b000, 1'b1, 1'b1, 3'b111, 3'b000, 3'b001, 1'b0, 8'h00, 1'b1, 2'd1, 1'b0};
        vecs[14] = '{3'b000, 1'b1, 1'b0, 3'b111, 3'b000, 3'b000, 1'b0, 8'h00, 1'b1, 2'd0, 1'b0};
        vecs[15] = '{3'b001, 1'b1, 1'b0, 3'b111, 3'b001, 3'b000, 1'b1, 8'h10, 1'b1, 2'd0, 1'b0};
        vecs[16] = '{3'b010, 1'b1, 1'b0, 3'b111, 3'b010, 3'b000, 1'b1, 8'h11, 1'b1, 2'd1, 1'b0};
        vecs[17] = '{3'b100, 1'b1, 1'b1, 3'b111, 3'b000, 3'b001, 1'b0, 8'h00, 1'b1, 2'd2, 1'b0};
        vecs[18] = '{3'b100, 1'b1, 1'b0, 3'b111, 3'b100, 3'b000, 1'b1, 8'h12, 1'b1, 2'd1, 1'b0};
        vecs[19] = '{3'b000, 1'b1, 1'b1, 3'b111, 3'b000, 3'b010, 1'b0, 8'h00, 1'b1, 2'd2, 1'b0};
        vecs[20] = '{3'b001, 1'b1, 1'b1, 3'b111, 3'b001, 3'b100, 1'b1, 8'h10, 1'b1, 2'd1, 1'b0};
        vecs[21] = '{3'b000, 1'b1, 1'b1, 3'b111, 3'b000, 3'b001, 1'b0, 8'h00, 1'b1, 2'd1, 1'b0};
        vecs[22] = '{3'b000, 1'b1, 1'b1, 3'b111, 3'b000, 3'b000, 1'b0, 8'h00, 1'b1, 2'd0, 1'b0};
        vecs[23] = '{3'b000, 1'b1, 1'b0, 3'b111, 3'b000, 3'b000, 1'b0, 8'h00, 1'b1, 2'd0, 1'b1};
        vecs[24] = '{3'b000, 1'b1, 1'b0, 3'b111, 3'b000, 3'b000, 1'b0, 8'h00, 1'b1, 2'd0, 1'b1};

        reset_dut();
        for (int k = 0; k < 25; k++) begin
            d_rsp.d_data = 32'hCAFE_0000 + 32'(k);
            step(vecs[k].av, vecs[k].dar, vecs[k].ddv, vecs[k].dr);
            check_output($sformatf("v%0d.a_ready", k), 32'(a_ready_bits), 32'(vecs[k].exp_ar));
            check_output($sformatf("v%0d.d_valid", k), 32'(d_valid_bits), 32'(vecs[k].exp_dv));
            check_output($sformatf("v%0d.dev_a_valid", k), 32'(d_req.a_valid), 32'(vecs[k].exp_dav));
            check_output($sformatf("v%0d.dev_d_ready", k), 32'(d_req.d_ready), 32'(vecs[k].exp_drdy));
            check_output($sformatf("v%0d.outstanding", k), 32'(outstanding), 32'(vecs[k].exp_out));
            check_output($sformatf("v%0d.spurious", k), 32'(spurious), 32'(vecs[k].exp_spur));
            if (vecs[k].exp_dav) begin
                check_output($sformatf("v%0d.a_source", k), 32'(d_req.a_source), 32'(vecs[k].exp_src));
                check_output($sformatf("v%0d.a_data", k), d_req.a_data,
                             32'hDA7A_0000 | 32'(vecs[k].exp_src[1:0]));
            end
            for (int i = 0; i < NumHosts; i++) begin
                if (vecs[k].exp_dv[i]) begin
                    check_output($sformatf("v%0d.d_data%0d", k, i), h_rsp[i].d_data, 32'hCAFE_0000 + 32'(k));
                end
            end
        end

        // All three hosts request continuously; device accepts every cycle and answers one cycle later.
        reset_dut();
        check_output("rst.spurious_clear", 32'(spurious), 32'd0);
        check_output("rst.outstanding", 32'(outstanding), 32'd0);
        for (int c = 0; c < 6; c++) begin
            logic [2:0] exp_grant;
`ifdef TLUL_XBAR_RR_ARB_EN
            exp_grant = 3'b001 << (c % 3);
`else
            exp_grant = 3'b001;
`endif
            step(3'b111, 1'b1, (c > 0), 3'b111);
            check_output($sformatf("arb%0d.grant", c), 32'(a_ready_bits), 32'(exp_grant));
        end

        // Back-to-back requests with responses withheld until the FIFO has filled.
        reset_dut();
        step(3'b001, 1'b1, 1'b0, 3'b111);
        check_output("full.c1.a_ready", 32'(a_ready_bits), 32'b001);
        step(3'b010, 1'b1, 1'b0, 3'b111);
        check_output("full.c2.a_ready", 32'(a_ready_bits), 32'b010);
        step(3'b100, 1'b1, 1'b0, 3'b111);
        check_output("full.c3.a_ready", 32'(a_ready_bits), 32'b000);
        check_output("full.c3.outstanding", 32'(outstanding), 32'd2);
        check_output("full.c3.dev_a_valid", 32'(d_req.a_valid), 32'd0);
        step(3'b100, 1'b1, 1'b0, 3'b111);
        check_output("full.c4.a_ready", 32'(a_ready_bits), 32'b000);
        step(3'b100, 1'b1, 1'b1, 3'b111);
        check_output("full.c5.a_ready", 32'(a_ready_bits), 32'b000);
        check_output("full.c5.d_valid", 32'(d_valid_bits), 32'b001);
        step(3'b100, 1'b1, 1'b0, 3'b111);
        check_output("full.c6.a_ready", 32'(a_ready_bits), 32'b100);
        check_output("full.c6.outstanding", 32'(outstanding), 32'd1);
        step(3'b000, 1'b1, 1'b0, 3'b111);
        check_output("full.c7.outstanding", 32'(outstanding), 32'd2);

        // Asynchronous reset with two entries outstanding and the arbiter pointer moved off zero.
        reset_dut();
        step(3'b001, 1'b1, 1'b0, 3'b111);
        step(3'b010, 1'b1, 1'b0, 3'b111);
        step(3'b111, 1'b0, 1'b1, 3'b111);
        check_output("arst.pre.outstanding", 32'(outstanding), 32'd2);
        rst = 1'b1;
        #1;
        check_output("arst.outstanding", 32'(outstanding), 32'd0);
        check_output("arst.a_ready", 32'(a_ready_bits), 32'b000);
        check_output("arst.d_valid", 32'(d_valid_bits), 32'b000);
        check_output("arst.dev_a_valid", 32'(d_req.a_valid), 32'd0);
        check_output("arst.dev_d_ready", 32'(d_req.d_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        apply_stimulus(3'b000, 1'b1, 1'b1, 3'b111);
        #2;
        check_output("arst.stale.d_valid", 32'(d_valid_bits), 32'b000);
        check_output("arst.stale.dev_d_ready", 32'(d_req.d_ready), 32'd1);
        step(3'b111, 1'b1, 1'b0, 3'b111);
        check_output("arst.spurious", 32'(spurious), 32'd1);
        check_output("arst.first_grant", 32'(a_ready_bits), 32'b001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tlul_xbar_nto1.md
TLUL_XBAR_NTO1 -- requirements
Module: tlul_xbar_nto1

Interface
REQ-001 SHALL have parameter NumHosts, default 3, number of upstream TL-UL hosts (2..8).
REQ-002 SHALL have parameter MaxOutstanding, default 4, depth of the response-routing FIFO (1..16).
REQ-003 SHALL have port clk_i  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port tl_h_i  input  NumHosts x tlul_pkg::tl_h2d_t  host requests.
REQ-006 SHALL have port tl_h_o  output  NumHosts x tlul_pkg::tl_d2h_t  host responses.
REQ-007 SHALL have port tl_d_o  output  tlul_pkg::tl_h2d_t  request to the single device.
REQ-008 SHALL have port tl_d_i  input  tlul_pkg::tl_d2h_t  device response.
REQ-009 SHALL have port outstanding_o  output  $clog2(MaxOutstanding+1)  current routing-FIFO occupancy.
REQ-010 SHALL have port spurious_rsp_o  output  1  sticky flag: device response with no outstanding request.

Function
REQ-011 SHALL hold grant state: IDLE (no owner) or LOCKED(k) (host k owns A channel).
REQ-012 In IDLE, with FIFO not full, SHALL select one requesting host (a_valid=1) combinationally and forward it the same cycle (0-cycle A latency).
REQ-013 SHALL forward all A-channel fields of the selected host to tl_d_o unmodified, and tl_d_i.a_ready only to that host; all other hosts see a_ready=0.
REQ-014 If selected host k's request is not accepted (device a_ready=0), SHALL move to LOCKED(k) and keep k selected until handshake, regardless of other requests.
REQ-015 On A handshake SHALL push k into the routing FIFO and return to IDLE the next cycle.
REQ-016 When FIFO full, SHALL drive tl_d_o.a_valid=0 and a_ready=0 to all hosts in IDLE; a same-cycle D pop does not unblock that cycle. LOCKED(k) is entered only when FIFO has space.
REQ-017 SHALL route tl_d_i.d_valid and D fields to the host at FIFO head; tl_d_o.d_ready SHALL equal that host's d_ready; other hosts see d_valid=0.
REQ-018 On D handshake SHALL pop the FIFO head; simultaneous push and pop SHALL leave occupancy unchanged and preserve order.
REQ-019 With FIFO empty, SHALL drive tl_d_o.d_ready=1, deliver d_valid to no host, and set spurious_rsp_o on tl_d_i.d_valid=1.
REQ-020 outstanding_o SHALL increment on push, decrement on pop, never exceed MaxOutstanding, and wrap FIFO pointers modulo MaxOutstanding.
REQ-021 The device SHALL return responses in request order; no reordering by d_source is performed.

Reset
REQ-022 While rst_i=1: grant state IDLE, FIFO empty, outstanding_o=0, spurious_rsp_o=0, priority pointer=0.
REQ-023 Reset asserted mid-transaction SHALL discard all outstanding routing entries; responses arriving after release are treated per REQ-019.
REQ-024 During reset all tl_h_o a_ready/d_valid and tl_d_o.a_valid SHALL be 0; tl_d_o.d_ready SHALL be 1.

Configuration
REQ-025 Macro TLUL_XBAR_RR_ARB_EN defined: IDLE selection SHALL be round-robin, searching from priority pointer; after A handshake by host k pointer becomes (k+1) mod NumHosts.
REQ-026 Macro TLUL_XBAR_RR_ARB_EN undefined: IDLE selection SHALL be fixed priority, lowest index wins; no pointer state is implemented.

Verification (NumHosts=3, MaxOutstanding=2)
REQ-027 Hosts 0,1,2 assert a_valid continuously, device always ready, responses 1 cycle later -> with RR: grants 0,1,2,0,...; without RR: host 0 only.
REQ-028 Host 1 requests, device a_ready=0 for 3 cycles, host 0 requests in cycle 2 -> tl_d_o carries host 1 fields stable all 4 cycles; host 0 granted after host 1 handshake.
REQ-029 Three back-to-back requests, device withholds D -> outstanding_o reaches 2, third host sees a_ready=0 until first D handshake, then is accepted the following cycle.
REQ-030 Requests from hosts 2 then 0 accepted; device returns two responses -> first d_valid to host 2, second to host 0; outstanding_o returns to 0.
REQ-031 d_valid=1 from device with FIFO empty -> no host sees d_valid, tl_d_o.d_ready=1, spurious_rsp_o=1 until rst_i.
REQ-032 rst_i pulsed with outstanding_o=2 -> outstanding_o=0, state IDLE, RR pointer 0 immediately (asynchronous).
